inv_bank_arbiter: RTL and testbench

Time-shares one 8-bit combinational user datapath, such as an inverter bank driven on `io_in` and read on `io_out`, among several requesters. Requesters are served in round-robin order. For each accepted request the block drives the operand onto the datapath, waits a fixed settle time, captures the result and returns it tagged with the requester ID. It sits between the per-requester front-ends and the shared 8-in/8-out tile.

---
 rtl/inv_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/inv_bank_arbiter.sv | 99 +++++++++
 tb/tb_inv_bank_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_arb_pkg.sv
// inv_arb_pkg: shared states, defaults and width helper for the inverter-bank arbiter
package inv_arb_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int SETTLE_DEF = 2;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap modulo N_REQ
module rr_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             any
);
    logic [IW-1:0] idx [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_idx
        assign idx[k] = IW'((int'(ptr) + k) % N_REQ);
    end
    always_comb begin
        gnt_id = ptr;
        any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[idx[k]]) begin
                gnt_id = idx[k];
                any = 1'b1;
            end
        end
        gnt = '0;
        gnt[gnt_id] = any;
    end
endmodule

// File: rtl/inv_bank_arbiter.sv
// inv_bank_arbiter: time-shares one combinational datapath among N_REQ requesters, round-robin,
// holding each operand for SETTLE cycles before capturing and returning the tagged result
module inv_bank_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW = DW_DEF,
    parameter int SETTLE = SETTLE_DEF,
    localparam int IW = id_w(N_REQ),
    localparam int CW = $clog2(SETTLE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]  req_ready,
    output logic [DW-1:0]     dp_in,
    input  logic [DW-1:0]     dp_out,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [DW-1:0]     rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, gnt_id;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dp_in_q, dp_in_d, rsp_data_q, rsp_data_d;
    logic rsp_valid_q, rsp_valid_d, any;
    logic [N_REQ-1:0] gnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .any   (any)
    );

    // rst_n gating keeps the strobe quiet while reset is held, not just after it lands
    assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign dp_in = dp_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign busy = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        dp_in_d = dp_in_q;
        rsp_id_d = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (any) begin
                dp_in_d = req_data[gnt_id*DW +: DW];
                rsp_id_d = gnt_id;
                cnt_d = CW'(SETTLE);
                ptr_d = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + IW'(1);
                state_d = DRIVE;
            end
            DRIVE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_data_d = dp_out;
                    rsp_valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            dp_in_q <= '0;
            rsp_id_q <= '0;
            rsp_data_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            dp_in_q <= dp_in_d;
            rsp_id_q <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_inv_bank_arbiter.sv
// tb_inv_bank_arbiter: scoreboard bench; stimulus queues expected grants/results, a monitor pops and compares
module tb_inv_bank_arbiter;
    localparam int ST = 2;
    typedef struct packed {logic [1:0] id; logic [7:0] data;} rsp_t;

    logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
    logic [3:0] req_valid = '0, req_ready;
    logic [31:0] req_data = '0;
    logic [7:0] dp_in, dp_out, rsp_data;
    logic [1:0] rsp_id;
    logic rsp_valid, busy;

    logic [2:0] v3 = '0, r3_ready;
    logic [23:0] d3 = '0;
    logic [7:0] dp3_in, dp3_out, rd3;
    logic [1:0] rid3;
    logic rv3, busy3;

    int total = 0, bad = 0, cyc = 0;
    logic [3:0] exp_gnt[$];
    rsp_t exp_rsp[$];
    int acc_log[$];

    assign dp_out = ~dp_in;
    assign dp3_out = ~dp3_in;

    inv_bank_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dp_in(dp_in), .dp_out(dp_out), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
    );

    inv_bank_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
        .req_ready(r3_ready), .dp_in(dp3_in), .dp_out(dp3_out), .rsp_valid(rv3),
        .rsp_id(rid3), .rsp_data(rd3), .rsp_ready(1'b1), .busy(busy3)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic [7:0] d);
        exp_gnt.push_back(g);
        exp_rsp.push_back('{id: id, data: d});
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 60 && acc_log.size() < n; k++) step();
        chk("accept_count", acc_log.size(), n);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (exp_rsp.size() != 0 || busy); k++) step();
        chk("drain_left", exp_rsp.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // monitor: grants and responses against the scoreboard queues
    initial begin
        logic prev_rv;
        logic [7:0] op;
        logic [3:0] eg;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready != 0) begin
                acc_log.push_back(cyc + 1);
                if (exp_gnt.size() == 0) chk("gnt_unexpected", req_ready, 0);
                else begin
                    eg = exp_gnt.pop_front();
                    chk("gnt", req_ready, eg);
                end
            end
            if (busy && !rsp_valid && exp_rsp.size() != 0) begin
                op = ~exp_rsp[0].data;
                chk("dp_in_hold", dp_in, op);
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    chk("rsp_id", rsp_id, exp_rsp[0].id);
                    chk("rsp_data", rsp_data, exp_rsp[0].data);
                    if (!prev_rv) chk("rsp_latency", cyc - acc_log[$], ST);
                    if (rsp_ready) void'(exp_rsp.pop_front());
                end
            end
            prev_rv = rsp_valid;
        end
    end

    initial begin
        int base;
        // reset with every requester asking
        req_valid = 4'hF;
        req_data = 32'hDEADBEEF;
        v3 = 3'b111;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dp_in", dp_in, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_r3_ready", r3_ready, 0);
        req_valid = '0;
        v3 = '0;
        rst_n = 1'b1;
        step();

        // fairness: 0,1,2,3,0,1 spaced SETTLE+2 apart
        base = acc_log.size();
        req_data = 32'h31_21_11_01;
        push(4'b0001, 0, 8'hFE);
        push(4'b0010, 1, 8'hEE);
        push(4'b0100, 2, 8'hDE);
        push(4'b1000, 3, 8'hCE);
        push(4'b0001, 0, 8'hFE);
        push(4'b0010, 1, 8'hEE);
        req_valid = 4'hF;
        wait_acc(base + 6);
        req_valid = '0;
        if (acc_log.size() >= base + 6)
            for (int i = 1; i < 6; i++) chk("fair_gap", acc_log[base+i] - acc_log[base+i-1], ST + 2);
        drain();

        // single request from requester 2
        base = acc_log.size();
        req_data[23:16] = 8'hA5;
        push(4'b0100, 2, 8'h5A);
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        wait_acc(base + 1);
        req_valid = '0;
        chk("single_dp_in", dp_in, 8'hA5);
        chk("single_busy", busy, 1);
        drain();

        // backpressure: requester 1 waits behind a stalled response
        base = acc_log.size();
        rsp_ready = 1'b0;
        req_data[7:0] = 8'h0F;
        req_data[15:8] = 8'hC3;
        push(4'b0001, 0, 8'hF0);
        req_valid = 4'b0001;
        wait_acc(base + 1);
        push(4'b0010, 1, 8'h3C);
        req_valid = 4'b0010;
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (5) begin
            chk("bp_ready_low", req_ready, 0);
            chk("bp_valid_held", rsp_valid, 1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_grant", req_ready, 4'b0010);
        wait_acc(base + 2);
        req_valid = '0;
        drain();

        // reset mid-DRIVE discards the transaction and returns ptr to 0
        base = acc_log.size();
        req_data = 32'h34_77_00_12;
        push(4'b0100, 2, 8'h88);
        req_valid = 4'b0100;
        wait_acc(base + 1);
        req_valid = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        exp_rsp.delete();
        push(4'b0001, 0, 8'hED);
        push(4'b1000, 3, 8'hCB);
        repeat (2) step();
        rst_n = 1'b1;
        wait_acc(base + 2);
        req_valid = 4'b1000;
        wait_acc(base + 3);
        req_valid = '0;
        drain();

        // pointer wrap on a 3-requester instance
        d3 = 24'h99_00_42;
        v3 = 3'b100;
        #1 chk("wrap_first", r3_ready, 3'b100);
        step();
        v3 = '0;
        for (int k = 0; k < 10 && !rv3; k++) step();
        chk("wrap_rsp_id2", rid3, 2);
        chk("wrap_rsp_data2", rd3, 8'h66);
        step();
        v3 = 3'b101;
        #1 chk("wrap_ptr0", r3_ready, 3'b001);
        step();
        v3 = '0;
        for (int k = 0; k < 10 && !rv3; k++) step();
        chk("wrap_rsp_id0", rid3, 0);
        chk("wrap_rsp_data0", rd3, 8'hBD);
        step();

        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
